// File: rtl/mul_pipe_if.sv
// Request/response handshake bundle for mul_pipe: issue side (in_*) and writeback side (out_*).
// The issuing/consuming logic uses the master modport and the multiplier uses the slave modport.
interface mul_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] c;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, op, a, b, tag, out_ready,
        input  in_ready, out_valid, c, out_tag
    );

    modport slave (
        input  in_valid, op, a, b, tag, out_ready,
        output in_ready, out_valid, c, out_tag
    );
endinterface

// File: rtl/mul_pipe.sv
// Pipelined RV32M-style multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready on both sides and tag pass-through.
// Optional macro MUL_PIPE_STATS_EN adds ops_done / stall_cycles counters.
module mul_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic        clock,
    input  logic        rstn,
    input  logic        flush,
    mul_pipe_if.slave   bus
`ifdef MUL_PIPE_STATS_EN
    ,
    output logic [31:0] ops_done,
    output logic [31:0] stall_cycles
`endif
);

    logic [STAGES:1] v;
    logic [STAGES:1] adv;
    logic            accept;

    // Low 2*WIDTH bits of the (WIDTH+1)x(WIDTH+1) signed product equal this modular product.
    function automatic logic [WIDTH-1:0] mul_res(input logic [1:0] sel,
                                                 input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] xe;
        logic [2*WIDTH-1:0] ye;
        logic [2*WIDTH-1:0] prod;
        logic               xs;
        logic               ys;
        xs   = (sel == 2'b01 || sel == 2'b10) & x[WIDTH-1];
        ys   = (sel == 2'b01) & y[WIDTH-1];
        xe   = {{WIDTH{xs}}, x};
        ye   = {{WIDTH{ys}}, y};
        prod = xe * ye;
        return (sel == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    endfunction

    // Advance chain resolves from the output back toward stage 1 so bubbles collapse.
    always_comb begin
        adv         = '0;
        adv[STAGES] = v[STAGES] & bus.out_ready;
        for (int i = STAGES - 1; i >= 1; i--) begin
            adv[i] = v[i] & (~v[i+1] | adv[i+1]);
        end
    end

    assign bus.in_ready  = ~flush & (~v[1] | adv[1]);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out_valid = v[STAGES];

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            v[1] <= accept | (v[1] & ~adv[1]);
            for (int i = 2; i <= STAGES; i++) begin
                v[i] <= adv[i-1] | (v[i] & ~adv[i]);
            end
        end
    end

    generate
        if (STAGES == 1) begin : g_one
            logic [WIDTH-1:0] c_q;
            logic [TAG_W-1:0] tag_q;

            always_ff @(posedge clock or negedge rstn) begin
                if (!rstn) begin
                    c_q   <= '0;
                    tag_q <= '0;
                end else if (accept) begin
                    c_q   <= mul_res(bus.op, bus.a, bus.b);
                    tag_q <= bus.tag;
                end
            end

            assign bus.c       = c_q;
            assign bus.out_tag = tag_q;
        end else begin : g_multi
            logic [1:0]       op_q;
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [TAG_W-1:0] tag1_q;
            logic [WIDTH-1:0] res_q  [2:STAGES];
            logic [TAG_W-1:0] rtag_q [2:STAGES];

            always_ff @(posedge clock or negedge rstn) begin
                if (!rstn) begin
                    op_q   <= '0;
                    a_q    <= '0;
                    b_q    <= '0;
                    tag1_q <= '0;
                end else if (accept) begin
                    op_q   <= bus.op;
                    a_q    <= bus.a;
                    b_q    <= bus.b;
                    tag1_q <= bus.tag;
                end
            end

            always_ff @(posedge clock or negedge rstn) begin
                if (!rstn) begin
                    for (int i = 2; i <= STAGES; i++) begin
                        res_q[i]  <= '0;
                        rtag_q[i] <= '0;
                    end
                end else begin
                    if (adv[1]) begin
                        res_q[2]  <= mul_res(op_q, a_q, b_q);
                        rtag_q[2] <= tag1_q;
                    end
                    for (int i = 3; i <= STAGES; i++) begin
                        if (adv[i-1]) begin
                            res_q[i]  <= res_q[i-1];
                            rtag_q[i] <= rtag_q[i-1];
                        end
                    end
                end
            end

            assign bus.c       = res_q[STAGES];
            assign bus.out_tag = rtag_q[STAGES];
        end
    endgenerate

`ifdef MUL_PIPE_STATS_EN
    // Statistics survive flush; only reset clears them.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            ops_done     <= '0;
            stall_cycles <= '0;
        end else begin
            if (bus.out_valid & bus.out_ready) begin
                ops_done <= ops_done + 32'd1;
            end
            if (bus.out_valid & ~bus.out_ready) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe (WIDTH=32, STAGES=3, TAG_W=4); stats checks build with MUL_PIPE_STATS_EN.
module tb_mul_pipe;
    localparam int ST = 3;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] c;
    } exp_t;

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] c;
        int          cyc;
    } obs_t;

    logic clock = 1'b0;
    logic rstn;
    logic flush;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   hs_cnt = 0;
    int   stall_cnt = 0;
    exp_t exq[$];
    obs_t obs[$];

`ifdef MUL_PIPE_STATS_EN
    logic [31:0] ops_done;
    logic [31:0] stall_cycles;
`endif

    mul_pipe_if #(.WIDTH(32), .TAG_W(4)) bus ();

    mul_pipe #(.WIDTH(32), .STAGES(ST), .TAG_W(4)) dut (
        .clock (clock),
        .rstn  (rstn),
        .flush (flush),
        .bus   (bus)
`ifdef MUL_PIPE_STATS_EN
        ,
        .ops_done     (ops_done),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Records each handshake that the following rising edge will complete.
    always @(negedge clock) begin
        obs_t ob;
        if (!rstn) begin
            hs_cnt    = 0;
            stall_cnt = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                ob.tag = bus.out_tag;
                ob.c   = bus.c;
                ob.cyc = cyc + 1;
                obs.push_back(ob);
                hs_cnt++;
            end
            if (bus.out_valid && !bus.out_ready) stall_cnt++;
        end
    end

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint xa;
        longint yb;
        longint p;
        xa = (o == 2'b01 || o == 2'b10) ? longint'($signed(x)) : longint'({32'b0, x});
        yb = (o == 2'b01) ? longint'($signed(y)) : longint'({32'b0, y});
        p  = xa * yb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] t, input logic [31:0] exp_c, input bit push, output int acc);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        bus.tag = t;
        acc = -1;
        for (int k = 0; k < 60 && acc < 0; k++) begin
            @(negedge clock);
            if (bus.in_ready) begin
                @(posedge clock);
                #1;
                acc = cyc;
            end else begin
                @(posedge clock);
                #1;
            end
        end
        if (acc < 0) begin
            compared++;
            mismatched++;
            $display("FAIL issue_timeout tag %0d never accepted", t);
        end else if (push) begin
            e.tag = t;
            e.c = exp_c;
            exq.push_back(e);
        end
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        for (int k = 0; k < budget && obs.size() < n; k++) tick();
        ok = (obs.size() >= n);
    endtask

    task automatic test_reset();
        compared++;
        if (bus.out_valid !== 1'b0 || bus.c !== 32'h0 || bus.out_tag !== 4'h0) begin
            mismatched++;
            $display("FAIL reset_outputs got v=%b c=%h tag=%h, expected 0/0/0", bus.out_valid, bus.c, bus.out_tag);
        end
        compared++;
        if (bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_in_ready got %b expected 1", bus.in_ready);
        end
`ifdef MUL_PIPE_STATS_EN
        compared++;
        if (ops_done !== 32'h0 || stall_cycles !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_stats got %0d/%0d expected 0/0", ops_done, stall_cycles);
        end
`endif
    endtask

    task automatic test_latency();
        int acc;
        bit ok;
        obs_t o;
        bus.out_ready = 1'b1;
        issue(2'b00, 32'd7, 32'd6, 4'd3, 32'h0000002A, 1'b1, acc);
        idle();
        compared++;
        if (bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL lat_edge1 out_valid got %b expected 0", bus.out_valid);
        end
        tick();
        compared++;
        if (bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL lat_edge2 out_valid got %b expected 0", bus.out_valid);
        end
        tick();
        compared++;
        if (bus.out_valid !== 1'b1 || bus.c !== 32'h0000002A || bus.out_tag !== 4'd3) begin
            mismatched++;
            $display("FAIL lat_edge3 got v=%b c=%h tag=%0d expected 1/0000002a/3", bus.out_valid, bus.c, bus.out_tag);
        end
        wait_obs(1, 20, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL lat_timeout got %0d results expected 1", obs.size());
        end else begin
            o = obs.pop_front();
            compared++;
            if (o.cyc - acc !== ST) begin
                mismatched++;
                $display("FAIL lat_pop_edge got %0d edges expected %0d", o.cyc - acc, ST);
            end
        end
        exq.delete();
        obs.delete();
    endtask

    task automatic test_ops();
        logic [31:0] xs [8];
        logic [31:0] ys [8];
        logic [1:0]  os [8];
        logic [31:0] cs [8];
        int acc;
        int first;
        bit ok;
        exp_t e;
        obs_t o;
        xs = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
        ys = xs;
        os = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b11, 2'b00, 2'b10};
        cs = '{32'h00000001, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFE,
               32'h40000000, 32'h40000000, 32'h00000000, 32'hC0000000};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) issue(os[i], xs[i], ys[i], 4'(i + 8), cs[i], 1'b1, acc);
        idle();
        wait_obs(8, 40, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL ops_timeout got %0d results expected 8", obs.size());
        end
        first = (obs.size() > 0) ? obs[0].cyc : 0;
        for (int k = 0; exq.size() > 0 && obs.size() > 0; k++) begin
            e = exq.pop_front();
            o = obs.pop_front();
            compared++;
            if (o.c !== e.c || o.tag !== e.tag || o.cyc !== first + k) begin
                mismatched++;
                $display("FAIL ops_result got tag %0d c %h cyc %0d, expected tag %0d c %h cyc %0d",
                         o.tag, o.c, o.cyc, e.tag, e.c, first + k);
            end
        end
        exq.delete();
        obs.delete();
    endtask

    task automatic test_stall();
        logic [31:0] c0;
        logic [3:0]  t0;
        bit ok;
        exp_t e;
        obs_t o;
        bus.out_ready = 1'b1;
        fork
            begin
                int acc;
                for (int i = 0; i < 8; i++)
                    issue(2'(i), 32'(i * 37 + 5), 32'hFFFFFFF0 + 32'(i), 4'(i),
                          model(2'(i), 32'(i * 37 + 5), 32'hFFFFFFF0 + 32'(i)), 1'b1, acc);
                idle();
            end
            begin
                repeat (4) tick();
                bus.out_ready = 1'b0;
                c0 = bus.c;
                t0 = bus.out_tag;
                repeat (5) begin
                    tick();
                    compared++;
                    if (bus.out_valid !== 1'b1 || bus.c !== c0 || bus.out_tag !== t0) begin
                        mismatched++;
                        $display("FAIL stall_hold got v=%b c=%h tag=%0d expected 1/%h/%0d",
                                 bus.out_valid, bus.c, bus.out_tag, c0, t0);
                    end
                end
                compared++;
                if (bus.in_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL stall_in_ready got %b expected 0", bus.in_ready);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_obs(8, 60, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL stall_timeout got %0d results expected 8", obs.size());
        end
        while (exq.size() > 0 && obs.size() > 0) begin
            e = exq.pop_front();
            o = obs.pop_front();
            compared++;
            if (o.c !== e.c || o.tag !== e.tag) begin
                mismatched++;
                $display("FAIL stall_result got tag %0d c %h, expected tag %0d c %h", o.tag, o.c, e.tag, e.c);
            end
        end
        exq.delete();
        obs.delete();
`ifdef MUL_PIPE_STATS_EN
        compared++;
        if (ops_done !== 32'(hs_cnt) || stall_cycles !== 32'(stall_cnt)) begin
            mismatched++;
            $display("FAIL stats_counts got %0d/%0d expected %0d/%0d", ops_done, stall_cycles, hs_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_random();
        bit ok;
        exp_t e;
        obs_t o;
        bus.out_ready = 1'b1;
        fork
            begin
                int acc;
                logic [31:0] x;
                logic [31:0] y;
                logic [1:0]  p;
                for (int i = 0; i < 16; i++) begin
                    x = $urandom;
                    y = $urandom;
                    p = 2'($urandom_range(0, 3));
                    issue(p, x, y, 4'(i), model(p, x, y), 1'b1, acc);
                end
                idle();
            end
            begin
                repeat (40) begin
                    tick();
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_obs(16, 100, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL random_timeout got %0d results expected 16", obs.size());
        end
        while (exq.size() > 0 && obs.size() > 0) begin
            e = exq.pop_front();
            o = obs.pop_front();
            compared++;
            if (o.c !== e.c || o.tag !== e.tag) begin
                mismatched++;
                $display("FAIL random_result got tag %0d c %h, expected tag %0d c %h", o.tag, o.c, e.tag, e.c);
            end
        end
        exq.delete();
        obs.delete();
    endtask

    task automatic test_flush();
        int acc;
        bit ok;
        obs_t o;
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) issue(2'b00, 32'(i), 32'd3, 4'(i), 32'h0, 1'b0, acc);
        bus.tag = 4'd9;
        bus.a = 32'd100;
        flush = 1'b1;
        @(negedge clock);
        compared++;
        if (bus.in_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_in_ready got %b expected 0", bus.in_ready);
        end
        tick();
        flush = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        repeat (5) begin
            compared++;
            if (bus.out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL flush_stale out_valid got %b expected 0", bus.out_valid);
            end
            tick();
        end
        compared++;
        if (obs.size() !== 0) begin
            mismatched++;
            $display("FAIL flush_leak got %0d results expected 0", obs.size());
        end
        obs.delete();
        issue(2'b00, 32'd3, 32'd5, 4'd5, 32'd15, 1'b1, acc);
        idle();
        wait_obs(1, 20, ok);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL flush_next_timeout got %0d results expected 1", obs.size());
        end else begin
            o = obs.pop_front();
            compared++;
            if (o.c !== 32'd15 || o.tag !== 4'd5 || o.cyc - acc !== ST) begin
                mismatched++;
                $display("FAIL flush_next got c %h tag %0d edges %0d, expected 0000000f/5/%0d",
                         o.c, o.tag, o.cyc - acc, ST);
            end
        end
        exq.delete();
        obs.delete();
    endtask

    task automatic test_rst_mid();
        int acc;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) issue(2'b00, 32'd9, 32'd9, 4'(i + 1), 32'h0, 1'b0, acc);
        idle();
        compared++;
        if (bus.out_valid !== 1'b1 || bus.c !== 32'd81) begin
            mismatched++;
            $display("FAIL rst_pre got v=%b c=%h expected 1/00000051", bus.out_valid, bus.c);
        end
        rstn = 1'b0;
        #1;
        compared++;
        if (bus.out_valid !== 1'b0 || bus.c !== 32'h0 || bus.out_tag !== 4'h0 || bus.in_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL rst_async got v=%b c=%h tag=%h rdy=%b expected 0/0/0/1",
                     bus.out_valid, bus.c, bus.out_tag, bus.in_ready);
        end
        tick();
        rstn = 1'b1;
`ifdef MUL_PIPE_STATS_EN
        compared++;
        if (ops_done !== 32'h0 || stall_cycles !== 32'h0) begin
            mismatched++;
            $display("FAIL rst_stats got %0d/%0d expected 0/0", ops_done, stall_cycles);
        end
`endif
        bus.out_ready = 1'b1;
        repeat (6) tick();
        compared++;
        if (obs.size() !== 0 || bus.out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_stale got %0d results v=%b expected 0/0", obs.size(), bus.out_valid);
        end
        obs.delete();
    endtask

    initial begin
        rstn = 1'b0;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.op = 2'b00;
        bus.a = 32'h0;
        bus.b = 32'h0;
        bus.tag = 4'h0;
        repeat (3) tick();
        test_reset();
        rstn = 1'b1;
        tick();
        test_latency();
        test_ops();
        test_stall();
        test_random();
        test_flush();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
